// File: rtl/bus_share_pkg.sv
// Shared types and default sizes for the bus-share arbiter slice.
package bus_share_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    localparam int DEF_W     = 16;
    localparam int DEF_N_REQ = 4;
endpackage

// File: rtl/bus_share_arbiter_if.sv
// Requester/downstream signal bundle; the arbiter sits on the slave modport.
interface bus_share_arbiter_if
    import bus_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] data;
    logic               ready;
    logic [N_REQ-1:0]   gnt;
    logic [2:0]         owner;
    logic [W-1:0]       O;
    logic               valid;

    modport slave  (input req, data, ready, output gnt, owner, O, valid);
    modport master (output req, data, ready, input gnt, owner, O, valid);
endinterface

// File: rtl/bus_share_arbiter_rr_pick.sv
// Round-robin pick: rotate req so last_owner+1 sits at bit 0, find lowest set bit, rotate back.
module rr_pick
    import bus_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last_owner,
    output logic             any,
    output logic [2:0]       next_idx
);
    logic [N_REQ-1:0] w_rot;
    logic [2:0]       w_enc;
    logic [3:0]       w_sum;

    // 3-bit wrap of last_owner+1 is harmless: 8 mod 8 == 0 shifts by zero
    assign w_rot = N_REQ'({req, req} >> (last_owner + 3'd1));
    assign any   = |req;

    always_comb begin
        w_enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_enc = 3'(i);
        end
    end

    assign w_sum    = {1'b0, last_owner} + 4'd1 + {1'b0, w_enc};
    assign next_idx = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : w_sum[2:0];
endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin sharing of one W-bit bus among N_REQ requesters, with a per-grant transfer cap.
module bus_share_arbiter
    import bus_share_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int W        = DEF_W,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    bus_share_arbiter_if.slave bus
);
    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [2:0]       r_owner;
    logic [2:0]       r_last;
    logic [7:0]       r_hold;

    logic             w_any;
    logic [2:0]       w_next;
    logic             w_own_req;
    logic [W-1:0]     w_own_data;
    logic             w_valid;
    logic             w_xfer;
    logic             w_release;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (bus.req),
        .last_owner (r_last),
        .any        (w_any),
        .next_idx   (w_next)
    );

    always_comb begin
        w_own_req  = 1'b0;
        w_own_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_owner == 3'(k)) begin
                w_own_req  = bus.req[k];
                w_own_data = bus.data[k*W +: W];
            end
        end
    end

    // Owner's word goes straight through; only the owner's lane can reach O
    assign w_valid   = (r_state == GRANT) && w_own_req;
    assign w_xfer    = w_valid && bus.ready;
    assign w_release = !w_own_req || (w_xfer && (r_hold == 8'(MAX_HOLD - 1)));

    assign bus.valid = w_valid;
    assign bus.O     = w_valid ? w_own_data : '0;
    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_hold  <= '0;
            r_last  <= 3'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_owner <= w_next;
                        for (int k = 0; k < N_REQ; k++) r_gnt[k] <= (w_next == 3'(k));
                    end
                end
                GRANT: begin
                    // Releasing through IDLE gives the one-cycle bubble and demotes the old owner
                    if (w_release) begin
                        r_state <= IDLE;
                        r_last  <= r_owner;
                        r_owner <= '0;
                        r_gnt   <= '0;
                        r_hold  <= '0;
                    end else if (w_xfer) begin
                        r_hold  <= r_hold + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed checks of bus_share_arbiter; two instances cover MAX_HOLD=8 and MAX_HOLD=2.
module tb_bus_share_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] data;
    logic        ready;
    int          vecs = 0;
    int          miss = 0;
    int          xfers;

    always #5 clk = ~clk;

    bus_share_arbiter_if #(.N_REQ(4), .W(16)) bi8 ();
    bus_share_arbiter_if #(.N_REQ(4), .W(16)) bi2 ();

    assign bi8.req = req;  assign bi8.data = data;  assign bi8.ready = ready;
    assign bi2.req = req;  assign bi2.data = data;  assign bi2.ready = ready;

    bus_share_arbiter #(.N_REQ(4), .W(16), .MAX_HOLD(8)) dut8 (
        .clk(clk), .reset(reset), .bus(bi8.slave));
    bus_share_arbiter #(.N_REQ(4), .W(16), .MAX_HOLD(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bi2.slave));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; ready = 1'b0;
        nxt(); nxt();
        reset = 1'b0;
    endtask

    initial begin
        data = '0;
        do_reset();

        // single request, then drop
        chk("rst_gnt",   32'(bi8.gnt),   0);
        chk("rst_owner", 32'(bi8.owner), 0);
        chk("rst_valid", 32'(bi8.valid), 0);
        chk("rst_O",     32'(bi8.O),     0);
        req = 4'b0100; data[47:32] = 16'hBEEF; ready = 1'b1;
        nxt();
        chk("t1_gnt",   32'(bi8.gnt),   32'b0100);
        chk("t1_owner", 32'(bi8.owner), 2);
        chk("t1_valid", 32'(bi8.valid), 1);
        chk("t1_O",     32'(bi8.O),     32'hBEEF);
        nxt();
        chk("t1_O_hold", 32'(bi8.O), 32'hBEEF);
        req = 4'b0000;
        #1;
        chk("t1_drop_valid", 32'(bi8.valid), 0);
        chk("t1_drop_O",     32'(bi8.O),     0);
        chk("t1_drop_gnt",   32'(bi8.gnt),   32'b0100);
        nxt();
        chk("t1_rel_gnt",   32'(bi8.gnt),   0);
        chk("t1_rel_owner", 32'(bi8.owner), 0);

        // four contenders on the MAX_HOLD=2 instance
        do_reset();
        data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        req = 4'b1111; ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            xfers = 0;
            for (int c = 0; c < 2; c++) begin
                nxt();
                chk("rr_gnt",   32'(bi2.gnt),   32'(1 << e));
                chk("rr_owner", 32'(bi2.owner), 32'(e));
                chk("rr_O",     32'(bi2.O),     32'(16'hA000 + e));
                if (bi2.valid && ready) xfers++;
            end
            chk("rr_xfers", 32'(xfers), 2);
            nxt();
            chk("rr_bubble_gnt",   32'(bi2.gnt),   0);
            chk("rr_bubble_valid", 32'(bi2.valid), 0);
        end

        // backpressure, then sole requester hitting the limit
        do_reset();
        data = '0; data[31:16] = 16'h1234;
        req = 4'b0010; ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            nxt();
            chk("bp_gnt",   32'(bi8.gnt),   32'b0010);
            chk("bp_valid", 32'(bi8.valid), 1);
            chk("bp_O",     32'(bi8.O),     32'h1234);
        end
        ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            nxt();
            chk("lim_gnt",   32'(bi8.gnt),   32'b0010);
            chk("lim_valid", 32'(bi8.valid), 1);
        end
        nxt();
        chk("lim_bubble_gnt",   32'(bi8.gnt),   0);
        chk("lim_bubble_valid", 32'(bi8.valid), 0);
        nxt();
        chk("lim_regrant_gnt",   32'(bi8.gnt),   32'b0010);
        chk("lim_regrant_owner", 32'(bi8.owner), 1);

        // mid-grant arrival is not preempted
        do_reset();
        data = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
        req = 4'b0001; ready = 1'b1;
        nxt();
        chk("mg_gnt0", 32'(bi8.gnt), 32'b0001);
        req = 4'b1001; data[63:48] = 16'h5A5A;
        nxt();
        chk("mg_nopre_gnt", 32'(bi8.gnt), 32'b0001);
        chk("mg_nopre_O",   32'(bi8.O),   32'h0F0F);
        req = 4'b1000;
        nxt();
        chk("mg_bubble", 32'(bi8.gnt), 0);
        nxt();
        chk("mg_gnt3",   32'(bi8.gnt),   32'b1000);
        chk("mg_owner3", 32'(bi8.owner), 3);
        chk("mg_O3",     32'(bi8.O),     32'h5A5A);

        // reset while granted and valid
        reset = 1'b1; req = 4'b1111;
        nxt();
        chk("mr_gnt",   32'(bi8.gnt),   0);
        chk("mr_owner", 32'(bi8.owner), 0);
        chk("mr_valid", 32'(bi8.valid), 0);
        chk("mr_O",     32'(bi8.O),     0);
        reset = 1'b0;
        nxt();
        chk("mr_first_gnt",   32'(bi8.gnt),   32'b0001);
        chk("mr_first_owner", 32'(bi8.owner), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
